rf_dump_ctrl: RTL and testbench
===============================

// Module: rf_dump_ctrl
// PURPOSE
//   Read-side master for the 8x16 register file: on request, walks the RR1/RR2
//   read ports through all registers, two per pass (even on RR1, odd on RR2).
//   Captures RD1/RD2 into a 2-entry buffer and streams each register out as one
//   {index,data} beat over a valid/ready handshake.
//   Asserts stall for the whole dump so the core issues no WEn writes and the
//   snapshot stays consistent. Sits beside the datapath as a debug/scan port.
// PARAMETERS
//   NREG  8   number of registers dumped; even, >=2
//   AW    3   register address width, clog2(NREG)
//   DW    16  register data width
// PORTS
//   CLK        in   1   clock, rising edge
//   CLR        in   1   asynchronous, active-low reset
//   start      in   1   dump request; sampled in IDLE only
//   RR1        out  AW  read address to RF port 1 (even reg)
//   RR2        out  AW  read address to RF port 2 (odd reg)
//   RD1        in   DW  RF read data port 1 (combinational from RR1)
//   RD2        in   DW  RF read data port 2 (combinational from RR2)
//   stall      out  1   high while state != IDLE; core must hold WEn low
//   out_valid  out  1   output beat valid
//   out_ready  in   1   downstream accepts beat
//   out_idx    out  AW  register index of current beat
//   out_data   out  DW  register contents of current beat
//   done       out  1   one-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - CLR low (any time, async): state=IDLE, pair=0, buf0=buf1=0, out_valid=0,
//   done=0, stall=0, out_idx=0, out_data=0; RR1=0, RR2=1.
// - RR1={pair,1'b0}, RR2={pair,1'b1}; pair is an (AW-1)-bit counter.
// - FSM, all transitions on the CLK rising edge:
//   IDLE : start=1 -> READ (pair=0); else stay
//   READ : buf0<=RD1, buf1<=RD2 -> SEND0
//   SEND0: out_valid=1, out_idx={pair,0}, out_data=buf0; out_ready -> SEND1
//   SEND1: out_valid=1, out_idx={pair,1}, out_data=buf1; out_ready ->
//          pair==NREG/2-1 ? DONE : (pair<=pair+1, READ)
//   DONE : done=1, out_valid=0; -> IDLE, pair<=0
// - out_valid=1 with out_ready=0: out_idx/out_data held stable, state holds.
// - out_valid is 0 in IDLE, READ and DONE.
// - Latency: start sampled at edge t -> first out_valid during cycle t+2.
//   With out_ready tied high: 3 cycles/pair, done asserted 3*NREG/2 cycles
//   after start is sampled (12 for NREG=8); stall high 3*NREG/2+1 cycles.
// - start while not IDLE: ignored, no queuing.
// - start held high: a new dump begins on the edge after DONE (IDLE samples it).
// - pair wraps only via DONE; never increments past NREG/2-1.
// - RF writes during stall are a protocol violation. The block does not check
//   for them; the captured value is whatever RF returns in READ.
// - Reset mid-dump aborts immediately; no partial done pulse.
// TESTING
// - RF preloaded r0..r7=16'h1000+i, start pulse, out_ready=1 -> 8 beats,
//   idx 0..7, data 1000..1007, done on cycle 12 after start, stall 13 cycles.
// - Same preload, out_ready toggling 1,0,0,1 -> same 8 beats in order.
//   idx/data stable whenever out_valid=1 && out_ready=0; no beat lost/duplicated.
// - start re-pulsed during beat 3 -> ignored; exactly 8 beats and one done.
// - CLR low during SEND1 of pair 2 -> outputs at reset values same cycle.
//   Next start gives a full 8-beat dump from idx 0.
// - start held high 40 cycles, out_ready=1 -> back-to-back dumps; each ends with
//   a done pulse, IDLE visible 1 cycle between dumps.
// - RF r3=16'hFFFF, r4=16'h0000, others 16'hA5A5 -> beats show exactly these
//   values (checks even/odd port mapping: idx3 from RD2, idx4 from RD1).

Source files
------------

// File: rtl/rf_dump_ctrl_if.sv
// Output beat stream of the register-file dump port: one {index,data} beat per
// valid/ready handshake, driven by the dump controller (master) toward debug logic.
interface rf_dump_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;

  modport master (output out_valid, output out_idx, output out_data, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/rf_dump_ctrl.sv
// Register-file dump controller: walks both RF read ports two registers per pass,
// buffers the pair and streams it out as {index,data} beats while stalling the core.
module rf_dump_ctrl #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic [AW-1:0] rr1_o,
  output logic [AW-1:0] rr2_o,
  input  logic [DW-1:0] rd1_i,
  input  logic [DW-1:0] rd2_i,
  output logic          stall_o,
  output logic          done_o,
  rf_dump_ctrl_if.master out_if
);
  localparam int            PW        = AW - 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(NREG / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pair_q  <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          pair_d  = '0;
        end
      end
      READ: begin
        // RD1/RD2 are combinational from RR1/RR2, so the pair is captured here.
        buf0_d  = rd1_i;
        buf1_d  = rd2_i;
        state_d = SEND0;
      end
      SEND0: begin
        if (out_if.out_ready) state_d = SEND1;
      end
      SEND1: begin
        if (out_if.out_ready) begin
          if (pair_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            pair_d  = pair_q + PW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pair_d  = '0;
      end
      default: begin
        state_d = IDLE;
        pair_d  = '0;
      end
    endcase
  end

  always_comb begin
    rr1_o            = {pair_q, 1'b0};
    rr2_o            = {pair_q, 1'b1};
    stall_o          = (state_q != IDLE);
    done_o           = (state_q == DONE);
    out_if.out_valid = (state_q == SEND0) || (state_q == SEND1);
    out_if.out_idx   = {pair_q, state_q == SEND1};
    out_if.out_data  = (state_q == SEND1) ? buf1_q : buf0_q;
  end
endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Directed bench for rf_dump_ctrl: cycle table for the basic dump, then
// hand-written sequences for backpressure, restart, reset abort and held start.
module tb_rf_dump_ctrl;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rr1, rr2;
  logic [DW-1:0] rd1, rd2;
  logic          stall, done;
  logic [DW-1:0] rf [NREG];

  int passed = 0;
  int total  = 0;

  rf_dump_ctrl_if #(.AW(AW), .DW(DW)) dif ();

  rf_dump_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .rr1_o   (rr1),
    .rr2_o   (rr2),
    .rd1_i   (rd1),
    .rd2_i   (rd2),
    .stall_o (stall),
    .done_o  (done),
    .out_if  (dif)
  );

  assign rd1 = rf[rr1];
  assign rd2 = rf[rr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          ready;
    logic          exp_valid;
    logic [AW-1:0] exp_idx;
    logic [DW-1:0] exp_data;
    logic          exp_done;
    logic          exp_stall;
  } vec_t;

  vec_t vecs [15];

  logic [AW-1:0] idx_q  [$];
  logic [DW-1:0] data_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(dif.out_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_idx"},   32'(dif.out_idx), 32'd0);
    chk({tag, "_data"},  32'(dif.out_data), 32'd0);
    chk({tag, "_rr1"},   32'(rr1), 32'd0);
    chk({tag, "_rr2"},   32'(rr2), 32'd1);
  endtask

  // Starts a dump, drives out_ready per pattern (0: always 1, 1: 1,0,0,1 repeating),
  // optionally re-pulses start during beat restart_beat, then compares beats to rf.
  task automatic run_dump(input string tag, input int pattern, input int restart_beat);
    int            cyc   = 0;
    int            nd    = 0;
    int            nb    = 0;
    int            extra = 0;
    bit            fired = 0;
    logic          held  = 0;
    logic          rdy;
    logic [AW-1:0] hidx  = '0;
    logic [DW-1:0] hdata = '0;
    idx_q.delete();
    data_q.delete();
    start = 1'b1;
    dif.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (nd == 0 && cyc < 200) begin
      if (held) begin
        chk({tag, "_hold_valid"}, 32'(dif.out_valid), 32'd1);
        chk({tag, "_hold_idx"},   32'(dif.out_idx), 32'(hidx));
        chk({tag, "_hold_data"},  32'(dif.out_data), 32'(hdata));
      end
      if (done) nd++;
      rdy = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (restart_beat >= 0 && !fired && nb == restart_beat && dif.out_valid) begin
        start = 1'b1;
        fired = 1;
      end else begin
        start = 1'b0;
      end
      dif.out_ready = rdy;
      held  = dif.out_valid && !rdy;
      hidx  = dif.out_idx;
      hdata = dif.out_data;
      if (dif.out_valid && rdy) begin
        idx_q.push_back(dif.out_idx);
        data_q.push_back(dif.out_data);
        nb++;
      end
      if (nd == 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(nd), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || dif.out_valid) extra++;
    end
    chk({tag, "_extra_activity"}, 32'(extra), 32'd0);
    chk({tag, "_stall_after"}, 32'(stall), 32'd0);
    chk({tag, "_beats"}, 32'(nb), 32'(NREG));
    for (int i = 0; i < NREG && i < nb; i++) begin
      chk($sformatf("%s_beat%0d_idx", tag, i), 32'(idx_q[i]), 32'(i));
      chk($sformatf("%s_beat%0d_data", tag, i), 32'(data_q[i]), 32'(rf[i]));
    end
    dif.out_ready = 1'b0;
  endtask

  initial begin
    logic st_s [40];
    logic dn_s [40];
    int   guard;

    for (int i = 0; i < NREG; i++) rf[i] = 16'h1000 + 16'(i);

    // Cycle-by-cycle expectations with out_ready tied high: 3 cycles per pair,
    // done 12 edges after the start edge, stall for 13 cycles.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd0, 16'h1000, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'd1, 16'h1001, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 16'h1002, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd3, 16'h1003, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd4, 16'h1004, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'd5, 16'h1005, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd6, 16'h1006, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd7, 16'h1007, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    dif.out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      start = vecs[v].start;
      dif.out_ready = vecs[v].ready;
      @(posedge clk); #1;
      $display("vec %0d: valid=%0d idx=%0d data=%h done=%0d stall=%0d",
               v, dif.out_valid, dif.out_idx, dif.out_data, done, stall);
      chk($sformatf("vec%0d_valid", v), 32'(dif.out_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_done", v),  32'(done), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_stall", v), 32'(stall), 32'(vecs[v].exp_stall));
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_idx", v),  32'(dif.out_idx), 32'(vecs[v].exp_idx));
        chk($sformatf("vec%0d_data", v), 32'(dif.out_data), 32'(vecs[v].exp_data));
      end
    end
    start = 1'b0;

    run_dump("backpressure", 1, -1);
    $display("backpressure dump: %0d beats", idx_q.size());
    run_dump("restart", 0, 3);
    $display("restart-ignored dump: %0d beats", idx_q.size());

    // Abort during SEND1 of pair 2 (beat idx 5); outputs must reset the same cycle.
    start = 1'b1;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(dif.out_valid && dif.out_idx == 3'd5) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reached_idx5", 32'(guard < 50), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    $display("abort: valid=%0d stall=%0d idx=%0d", dif.out_valid, stall, dif.out_idx);
    @(negedge clk);
    rst_n = 1'b1;
    dif.out_ready = 1'b0;
    @(negedge clk);
    run_dump("after_abort", 0, -1);
    $display("post-abort dump: %0d beats", idx_q.size());

    // start held high: dumps back to back with one IDLE cycle between them.
    start = 1'b1;
    dif.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      st_s[c] = stall;
      dn_s[c] = done;
    end
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("held_done_c%0d", c),  32'(dn_s[c]), 32'(c == 12 || c == 26));
      chk($sformatf("held_stall_c%0d", c), 32'(st_s[c]), 32'(!(c == 13 || c == 27)));
    end
    $display("held start: done pulses at cycles 12 and 26 expected");
    guard = 0;
    while (stall && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("held_drain", 32'(stall), 32'd0);
    dif.out_ready = 1'b0;

    // Even/odd port mapping: idx3 comes from RD2, idx4 from RD1.
    for (int i = 0; i < NREG; i++) rf[i] = 16'hA5A5;
    rf[3] = 16'hFFFF;
    rf[4] = 16'h0000;
    run_dump("mapping", 0, -1);
    if (data_q.size() >= 5) begin
      chk("mapping_idx3_ffff", 32'(data_q[3]), 32'h0000FFFF);
      chk("mapping_idx4_0000", 32'(data_q[4]), 32'h00000000);
      chk("mapping_idx2_a5a5", 32'(data_q[2]), 32'h0000A5A5);
    end else begin
      chk("mapping_beat_count", 32'(data_q.size()), 32'(NREG));
    end
    $display("mapping dump: %0d beats", data_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
